// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg
//   Shared display constants for the 7-segment scan blocks: the 16 hex glyphs,
//   the all-off segment pattern and the active-low polarity of anodes and DP.
//   Glyph bit order is {g,f,e,d,c,b,a}, active low.
package seg7_scan_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic       AN_ON   = 1'b0;
   localparam logic       AN_OFF  = 1'b1;
   localparam logic       DP_ON   = 1'b0;
   localparam logic       DP_OFF  = 1'b1;

   // Counter width for a modulus n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] value);
      logic [6:0] g;
      case (value)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/count.sv
// count
//   Parametrizable mod-N up-counter. Counts 0..N-1 while ENABLE=1 and wraps.
//   TC is combinational: high while ENABLE=1 and COUNT==N-1.
// Ports
//   CLK     in   1   clock, rising edge
//   RSTn    in   1   asynchronous reset, active low
//   ENABLE  in   1   count enable
//   COUNT   out  W   current count (W = clog2(N), minimum 1)
//   TC      out  1   terminal count
module count
   import seg7_scan_pkg::*;
#(
   parameter  int N = 10,
   localparam int W = cnt_width(N)
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         ENABLE,
   output logic [W-1:0] COUNT,
   output logic         TC
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         COUNT <= '0;
      end else if (ENABLE) begin
         COUNT <= (COUNT == LAST) ? '0 : COUNT + 1'b1;
      end
   end

   assign TC = ENABLE && (COUNT == LAST);

endmodule

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational hex-to-7-segment decoder with a blank override.
// Ports
//   VALUE  in   4   hex digit value
//   BLANK  in   1   1 = force all segments off
//   SEG    out  7   segments {g,f,e,d,c,b,a}, active low
module seg7_decode
   import seg7_scan_pkg::*;
(
   input  logic [3:0] VALUE,
   input  logic       BLANK,
   output logic [6:0] SEG
);

   assign SEG = BLANK ? SEG_OFF : glyph(VALUE);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan
//   Multiplexed common-anode 7-segment scanner. One digit is lit per slot of
//   REFRESH_DIV cycles; the first BLANK_CYC cycles of each slot keep every anode
//   off to prevent ghosting. Inputs are snapshotted once per frame so a frame
//   never mixes old and new digit values.
// Ports
//   CLK       in   1        clock, rising edge
//   RSTn      in   1        asynchronous reset, active low
//   ENABLE    in   1        1 = scan runs; 0 = display dark, scan state held
//   DIGITS    in   4*NDIG   digit values, digit 0 in DIGITS[3:0] (rightmost)
//   DP_MASK   in   NDIG     decimal point request per digit, 1 = on
//   BLANK_LZ  in   1        1 = suppress leading zeros
//   AN        out  NDIG     anode enables, active low
//   SEG       out  7        segments {g,f,e,d,c,b,a}, active low
//   DP        out  1        decimal point, active low
//   FRAME_TC  out  1        one-cycle pulse at the end of the last slot
module seg7_scan
   import seg7_scan_pkg::*;
#(
   parameter int NDIG        = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              ENABLE,
   input  logic [4*NDIG-1:0] DIGITS,
   input  logic [NDIG-1:0]   DP_MASK,
   input  logic              BLANK_LZ,
   output logic [NDIG-1:0]   AN,
   output logic [6:0]        SEG,
   output logic              DP,
   output logic              FRAME_TC
);

   localparam int PCW  = cnt_width(REFRESH_DIV);
   localparam int IDXW = cnt_width(NDIG);

   logic [PCW-1:0]    pc;
   logic [IDXW-1:0]   idx;
   logic              pc_tc;
   logic              idx_tc;

   logic [4*NDIG-1:0] snap_dig;
   logic [NDIG-1:0]   snap_dp;
   logic              snap_blz;
   logic              first;

   logic [3:0]        sel_dig;
   logic              sel_dp;
   logic              sel_blank;
   logic              nz_above;
   logic              in_blank;
   logic [NDIG-1:0]   an_nxt;
   logic [6:0]        seg_nxt;

   // Prescaler paces the slots; its TC advances the digit index.
   count #(.N(REFRESH_DIV)) u_pc (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .ENABLE (ENABLE),
      .COUNT  (pc),
      .TC     (pc_tc)
   );

   count #(.N(NDIG)) u_idx (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .ENABLE (pc_tc),
      .COUNT  (idx),
      .TC     (idx_tc)
   );

   // The idx TC is already gated by the prescaler TC and ENABLE, so it marks
   // exactly the last cycle of the last slot.
   assign FRAME_TC = idx_tc;

   // Snapshot on the first clock after reset and whenever idx wraps to 0.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         snap_dig <= '0;
         snap_dp  <= '0;
         snap_blz <= 1'b0;
         first    <= 1'b1;
      end else begin
         first <= 1'b0;
         if (first || idx_tc) begin
            snap_dig <= DIGITS;
            snap_dp  <= DP_MASK;
            snap_blz <= BLANK_LZ;
         end
      end
   end

   // Walk digits from the most significant down: a digit is a leading zero
   // when it and everything above it are zero. Digit 0 always shows.
   always_comb begin
      sel_dig   = 4'h0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      nz_above  = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         nz_above = nz_above || (snap_dig[4*i +: 4] != 4'h0);
         if (idx == IDXW'(i)) begin
            sel_dig   = snap_dig[4*i +: 4];
            sel_dp    = snap_dp[i];
            sel_blank = snap_blz && !nz_above && (i != 0);
         end
      end
   end

   seg7_decode u_dec (
      .VALUE (sel_dig),
      .BLANK (sel_blank),
      .SEG   (seg_nxt)
   );

   assign in_blank = (BLANK_CYC > 0) && (int'(pc) < BLANK_CYC);

   always_comb begin
      an_nxt = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (!in_blank && (idx == IDXW'(i))) begin
            an_nxt[i] = AN_ON;
         end
      end
   end

   // Output registers: one cycle behind pc/idx; dark while disabled.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         AN  <= '1;
         SEG <= SEG_OFF;
         DP  <= DP_OFF;
      end else if (ENABLE) begin
         AN  <= an_nxt;
         SEG <= seg_nxt;
         DP  <= sel_dp ? DP_ON : DP_OFF;
      end else begin
         AN  <= '1;
         SEG <= SEG_OFF;
         DP  <= DP_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

   localparam int NDIG = 4;
   localparam int RD   = 8;
   localparam int BC   = 2;

   logic              CLK;
   logic              RSTn;
   logic              ENABLE;
   logic [4*NDIG-1:0] DIGITS;
   logic [NDIG-1:0]   DP_MASK;
   logic              BLANK_LZ;
   logic [NDIG-1:0]   AN;
   logic [6:0]        SEG;
   logic              DP;
   logic              FRAME_TC;

   seg7_scan #(.NDIG(NDIG), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .ENABLE   (ENABLE),
      .DIGITS   (DIGITS),
      .DP_MASK  (DP_MASK),
      .BLANK_LZ (BLANK_LZ),
      .AN       (AN),
      .SEG      (SEG),
      .DP       (DP),
      .FRAME_TC (FRAME_TC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] gly [16];

   // Reference model state: enabled edges since reset, and the frame snapshot.
   int          ec;
   bit          first;
   logic [15:0] s_dig;
   logic [3:0]  s_dp;
   bit          s_blz;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_tc;
   int          n_frames;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ec    = 0;
      first = 1;
      s_dig = '0;
      s_dp  = '0;
      s_blz = 0;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_tc  = 1'b0;
   endtask

   task automatic model_step();
      int pc, idx, d;
      bit blank;
      if (!RSTn) begin
         model_reset();
      end else begin
         pc  = ec % RD;
         idx = (ec / RD) % NDIG;
         if (ENABLE) begin
            d     = (s_dig >> (4 * idx)) & 15;
            blank = s_blz && (idx != 0) && ((s_dig >> (4 * idx)) == 0);
            e_an  = (pc < BC) ? 4'hF : ~(4'(1) << idx);
            e_seg = blank ? 7'h7F : gly[d];
            e_dp  = ~s_dp[idx];
         end else begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
         end
         if (first || (ENABLE && pc == RD - 1 && idx == NDIG - 1)) begin
            s_dig = DIGITS;
            s_dp  = DP_MASK;
            s_blz = BLANK_LZ;
         end
         first = 0;
         if (ENABLE) ec++;
         pc   = ec % RD;
         idx  = (ec / RD) % NDIG;
         e_tc = ENABLE && (pc == RD - 1) && (idx == NDIG - 1);
      end
   endtask

   task automatic compare();
      chk("AN", 32'(AN), 32'(e_an));
      chk("SEG", 32'(SEG), 32'(e_seg));
      chk("DP", 32'(DP), 32'(e_dp));
      chk("FRAME_TC", 32'(FRAME_TC), 32'(e_tc));
      if (FRAME_TC === 1'b1) n_frames++;
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
      compare();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         cycle();
      end
   endtask

   task automatic reset_pulse();
      @(negedge CLK);
      #2 RSTn = 1'b0;
      #1;
      chk("AN_async_rst", 32'(AN), 32'hF);
      chk("SEG_async_rst", 32'(SEG), 32'h7F);
      chk("DP_async_rst", 32'(DP), 32'h1);
      chk("TC_async_rst", 32'(FRAME_TC), 32'h0);
      model_reset();
      run(2);
      @(negedge CLK);
      RSTn = 1'b1;
      cycle();
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < NDIG; i++) begin
         if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   initial begin
      gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      n_frames = 0;
      RSTn     = 1'b0;
      ENABLE   = 1'b0;
      DIGITS   = '0;
      DP_MASK  = '0;
      BLANK_LZ = 1'b0;
      model_reset();
      run(3);

      // Scan of zeros, then directed patterns, each over whole frames.
      @(negedge CLK);
      RSTn   = 1'b1;
      ENABLE = 1'b1;
      cycle();
      run(40);
      DIGITS = 16'h1234;
      run(64);
      chk("frame_count", 32'(n_frames), 32'd3);
      BLANK_LZ = 1'b1;
      DIGITS   = 16'h0050;
      run(64);
      DIGITS = 16'h0000;
      run(40);
      BLANK_LZ = 1'b0;
      DIGITS   = 16'h1111;
      run(40);
      DIGITS  = 16'h2222;
      DP_MASK = 4'b0100;
      run(48);
      reset_pulse();
      run(40);

      // Randomized inputs, enable gaps and occasional resets.
      for (int k = 0; k < 1500; k++) begin
         @(negedge CLK);
         ENABLE = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) DIGITS = rand_digits();
         if ($urandom_range(0, 15) == 0) DP_MASK = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) BLANK_LZ = 1'($urandom_range(0, 1));
         cycle();
         if (k == 500 || k == 1100) reset_pulse();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
